// File: rtl/io_port_controller_if.sv
// Serial-side valid/ready bundle for io_port_controller.
// One byte lane per channel on each of the TX and RX directions.
interface io_port_controller_if #(
  parameter int CH = 2
);
  logic [CH*8-1:0] ser_tx_data;
  logic [CH-1:0]   ser_tx_valid;
  logic [CH-1:0]   ser_tx_ready;
  logic [CH*8-1:0] ser_rx_data;
  logic [CH-1:0]   ser_rx_valid;
  logic [CH-1:0]   ser_rx_error;
  logic [CH-1:0]   ser_rx_ready;

  modport master (
    output ser_tx_data,
    output ser_tx_valid,
    input  ser_tx_ready,
    input  ser_rx_data,
    input  ser_rx_valid,
    input  ser_rx_error,
    output ser_rx_ready
  );

  modport slave (
    input  ser_tx_data,
    input  ser_tx_valid,
    output ser_tx_ready,
    output ser_rx_data,
    output ser_rx_valid,
    output ser_rx_error,
    input  ser_rx_ready
  );
endinterface

// File: rtl/io_port_controller.sv
// Bus-mapped multi-channel serial IO controller with per-channel TX/RX FIFOs.
// All CPU transfers go through the 16-bit IO holding register.
module io_port_controller #(
  parameter int DATA_W     = 16,
  parameter int CH         = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  inout  wire [DATA_W-1:0]   bus,
  input  logic [2:0]         ctrl,
  io_port_controller_if.master ser,
  output logic               irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_TX_PUSH = 4'h1;
  localparam logic [3:0] OP_RX_POP  = 4'h2;
  localparam logic [3:0] OP_STATUS  = 4'h3;
  localparam logic [3:0] OP_FLUSH   = 4'h4;

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [15:0]   io_q, io_d;

  logic [7:0]    tx_mem_q [CH][FIFO_DEPTH];
  logic [7:0]    rx_mem_q [CH][FIFO_DEPTH];

  logic [AW-1:0] tx_wp_q [CH], tx_wp_d [CH];
  logic [AW-1:0] tx_rp_q [CH], tx_rp_d [CH];
  logic [AW-1:0] rx_wp_q [CH], rx_wp_d [CH];
  logic [AW-1:0] rx_rp_q [CH], rx_rp_d [CH];
  logic [CW-1:0] tx_cnt_q [CH], tx_cnt_d [CH];
  logic [CW-1:0] rx_cnt_q [CH], rx_cnt_d [CH];
  // Sticky bits: [0] rx_ovf, [1] rx_err, [2] tx_ovf, [3] rx_udf
  logic [3:0]    stk_q [CH], stk_d [CH];

  logic [CH-1:0] tx_we, rx_we;
  logic [CH-1:0] tx_valid, rx_ready;
  logic [CH*8-1:0] tx_data;

  logic [3:0]    cmd_op, cmd_ch;
  logic          cmd_ok;

  assign cmd_op = bus[3:0];
  assign cmd_ch = bus[7:4];
  assign cmd_ok = ctrl[2] && ({1'b0, cmd_ch} < 5'(CH));

  assign bus = ctrl[1] ? DATA_W'(io_q) : {DATA_W{1'bz}};

  always_comb begin
    irq = 1'b0;
    tx_data = '0;
    tx_valid = '0;
    rx_ready = '0;
    for (int c = 0; c < CH; c++) begin
      tx_data[8*c +: 8] = tx_mem_q[c][tx_rp_q[c]];
      tx_valid[c] = tx_cnt_q[c] != '0;
      rx_ready[c] = rx_cnt_q[c] != FULL_CNT;
      irq = irq | (rx_cnt_q[c] != '0) | stk_q[c][0] | stk_q[c][1];
    end
  end

  assign ser.ser_tx_data  = tx_data;
  assign ser.ser_tx_valid = tx_valid;
  assign ser.ser_rx_ready = rx_ready;

  always_comb begin
    logic sel, tx_full, tx_pop, tx_req, tx_push;
    logic rx_full, rx_empty, rx_pop_req, rx_pop, rx_push;
    sel = 1'b0;
    tx_full = 1'b0;
    tx_pop = 1'b0;
    tx_req = 1'b0;
    tx_push = 1'b0;
    rx_full = 1'b0;
    rx_empty = 1'b0;
    rx_pop_req = 1'b0;
    rx_pop = 1'b0;
    rx_push = 1'b0;
    tx_we = '0;
    rx_we = '0;
    io_d = io_q;
    if (ctrl[0] && !ctrl[2])
      io_d = bus[15:0];
    for (int c = 0; c < CH; c++) begin
      tx_wp_d[c]  = tx_wp_q[c];
      tx_rp_d[c]  = tx_rp_q[c];
      rx_wp_d[c]  = rx_wp_q[c];
      rx_rp_d[c]  = rx_rp_q[c];
      tx_cnt_d[c] = tx_cnt_q[c];
      rx_cnt_d[c] = rx_cnt_q[c];
      stk_d[c]    = stk_q[c];

      sel        = cmd_ok && (cmd_ch == 4'(c));
      tx_full    = tx_cnt_q[c] == FULL_CNT;
      tx_pop     = tx_valid[c] && ser.ser_tx_ready[c];
      tx_req     = sel && (cmd_op == OP_TX_PUSH);
      tx_push    = tx_req && (!tx_full || tx_pop);
      rx_full    = rx_cnt_q[c] == FULL_CNT;
      rx_empty   = rx_cnt_q[c] == '0;
      rx_pop_req = sel && (cmd_op == OP_RX_POP);
      rx_pop     = rx_pop_req && !rx_empty;
      // A pop in the same cycle frees the slot the serial byte lands in
      rx_push    = ser.ser_rx_valid[c] && (!rx_full || rx_pop);

      if (sel && (cmd_op == OP_STATUS)) begin
        io_d = {8'(rx_cnt_q[c]), stk_q[c], rx_empty, rx_full,
                tx_cnt_q[c] == '0, tx_full};
        stk_d[c] = '0;
      end
      if (rx_pop_req)
        io_d = rx_empty ? 16'h0000 : {8'h00, rx_mem_q[c][rx_rp_q[c]]};

      if (rx_pop_req && rx_empty)
        stk_d[c][3] = 1'b1;
      if (tx_req && tx_full && !tx_pop)
        stk_d[c][2] = 1'b1;
      if (ser.ser_rx_valid[c] && ser.ser_rx_error[c])
        stk_d[c][1] = 1'b1;
      if (ser.ser_rx_valid[c] && rx_full && !rx_pop)
        stk_d[c][0] = 1'b1;

      tx_we[c] = tx_push;
      rx_we[c] = rx_push;
      if (tx_push) tx_wp_d[c] = tx_wp_q[c] + AW'(1);
      if (tx_pop)  tx_rp_d[c] = tx_rp_q[c] + AW'(1);
      if (rx_push) rx_wp_d[c] = rx_wp_q[c] + AW'(1);
      if (rx_pop)  rx_rp_d[c] = rx_rp_q[c] + AW'(1);
      tx_cnt_d[c] = tx_cnt_q[c] + CW'(tx_push) - CW'(tx_pop);
      rx_cnt_d[c] = rx_cnt_q[c] + CW'(rx_push) - CW'(rx_pop);

      if (sel && (cmd_op == OP_FLUSH)) begin
        tx_we[c]    = 1'b0;
        rx_we[c]    = 1'b0;
        tx_wp_d[c]  = '0;
        tx_rp_d[c]  = '0;
        rx_wp_d[c]  = '0;
        rx_rp_d[c]  = '0;
        tx_cnt_d[c] = '0;
        rx_cnt_d[c] = '0;
        stk_d[c]    = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_q <= '0;
      for (int c = 0; c < CH; c++) begin
        tx_wp_q[c]  <= '0;
        tx_rp_q[c]  <= '0;
        rx_wp_q[c]  <= '0;
        rx_rp_q[c]  <= '0;
        tx_cnt_q[c] <= '0;
        rx_cnt_q[c] <= '0;
        stk_q[c]    <= '0;
      end
    end else begin
      io_q <= io_d;
      for (int c = 0; c < CH; c++) begin
        tx_wp_q[c]  <= tx_wp_d[c];
        tx_rp_q[c]  <= tx_rp_d[c];
        rx_wp_q[c]  <= rx_wp_d[c];
        rx_rp_q[c]  <= rx_rp_d[c];
        tx_cnt_q[c] <= tx_cnt_d[c];
        rx_cnt_q[c] <= rx_cnt_d[c];
        stk_q[c]    <= stk_d[c];
      end
    end
  end

  // Storage needs no reset: emptiness is carried by the counters
  always_ff @(posedge clock) begin
    for (int c = 0; c < CH; c++) begin
      if (tx_we[c]) tx_mem_q[c][tx_wp_q[c]] <= io_q[7:0];
      if (rx_we[c]) rx_mem_q[c][rx_wp_q[c]] <= ser.ser_rx_data[8*c +: 8];
    end
  end

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller, CH=2, depth 8.
// Expected values are queued as stimulus is driven and popped at each check.
module tb_io_port_controller;

  logic        clock;
  logic        reset_n;
  logic [2:0]  ctrl;
  logic        irq;
  logic [15:0] tb_bus;
  logic        tb_drv;
  wire  [15:0] bus;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [15:0] v;

  io_port_controller_if #(.CH(2)) sif ();

  assign bus = tb_drv ? tb_bus : 16'hzzzz;

  io_port_controller #(
    .DATA_W(16),
    .CH(2),
    .FIFO_DEPTH(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .ctrl(ctrl),
    .ser(sif.master),
    .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_v(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed %0h expected <queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic cmd(input logic [3:0] op, input logic [3:0] ch);
    tb_bus = {8'h00, ch, op};
    tb_drv = 1'b1;
    ctrl = 3'b100;
    tick();
    ctrl = 3'b000;
    tb_drv = 1'b0;
  endtask

  task automatic load(input logic [15:0] d);
    tb_bus = d;
    tb_drv = 1'b1;
    ctrl = 3'b001;
    tick();
    ctrl = 3'b000;
    tb_drv = 1'b0;
  endtask

  task automatic read_io(output logic [15:0] d);
    tb_drv = 1'b0;
    ctrl = 3'b010;
    #1;
    d = bus;
    ctrl = 3'b000;
  endtask

  initial begin
    reset_n = 1'b0;
    ctrl = 3'b000;
    tb_bus = 16'h0000;
    tb_drv = 1'b0;
    sif.ser_tx_ready = '0;
    sif.ser_rx_data = '0;
    sif.ser_rx_valid = '0;
    sif.ser_rx_error = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    expect_v(0); read_io(v); check("rst_io", v);
    expect_v(2'b11); check("rst_rx_ready", sif.ser_rx_ready);
    expect_v(2'b00); check("rst_tx_valid", sif.ser_tx_valid);
    expect_v(0); check("rst_irq", irq);
    tb_bus = 16'h1234; tb_drv = 1'b1; #1;
    expect_v(16'h1234); check("bus_released", bus);
    tb_drv = 1'b0;
    expect_v(16'h000A); cmd(4'h3, 4'h0); read_io(v); check("status_idle", v);

    // TX push on ch1 and single-cycle drain
    load(16'h0041);
    cmd(4'h1, 4'h1);
    expect_v(2'b10); check("tx_valid_ch1", sif.ser_tx_valid);
    expect_v(8'h41); check("tx_data_ch1", sif.ser_tx_data[15:8]);
    expect_v(16'h0041); read_io(v); check("io_kept", v);
    sif.ser_tx_ready = 2'b10;
    tick();
    sif.ser_tx_ready = 2'b00;
    expect_v(2'b00); check("tx_drained", sif.ser_tx_valid);

    // Overfill ch0 TX
    for (int i = 0; i < 9; i++) begin
      load(16'h0010 + 16'(i));
      cmd(4'h1, 4'h0);
    end
    expect_v(16'h0049); cmd(4'h3, 4'h0); read_io(v); check("tx_ovf_status", v);
    expect_v(16'h0009); cmd(4'h3, 4'h0); read_io(v); check("tx_ovf_clear", v);
    sif.ser_tx_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      expect_v(32'h10 + 32'(i));
      check("tx_order", sif.ser_tx_data[7:0]);
      tick();
    end
    sif.ser_tx_ready = 2'b00;
    expect_v(2'b00); check("tx_empty_after", sif.ser_tx_valid);

    // Serial RX on ch1 with an error byte
    sif.ser_rx_data = 16'h5500; sif.ser_rx_valid = 2'b10;
    tick();
    sif.ser_rx_data = 16'hAA00; sif.ser_rx_error = 2'b10;
    tick();
    sif.ser_rx_valid = 2'b00; sif.ser_rx_error = 2'b00;
    expect_v(1); check("irq_rx", irq);
    expect_v(16'h0222); cmd(4'h3, 4'h1); read_io(v); check("status_rx1", v);
    expect_v(16'h0055); cmd(4'h2, 4'h1); read_io(v); check("rx_pop0", v);
    expect_v(16'h00AA); cmd(4'h2, 4'h1); read_io(v); check("rx_pop1", v);
    expect_v(16'h0000); cmd(4'h2, 4'h1); read_io(v); check("rx_pop_udf", v);
    expect_v(16'h008A); cmd(4'h3, 4'h1); read_io(v); check("status_udf", v);
    expect_v(0); check("irq_clear", irq);

    // Fill ch0 RX, overflow, then pop and push together
    for (int i = 0; i < 8; i++) begin
      sif.ser_rx_data = 16'h0060 + 16'(i); sif.ser_rx_valid = 2'b01;
      tick();
    end
    expect_v(2'b10); check("rx_ready_full", sif.ser_rx_ready);
    sif.ser_rx_data = 16'h00EE;
    tick();
    sif.ser_rx_data = 16'h0070;
    cmd(4'h2, 4'h0);
    sif.ser_rx_valid = 2'b00;
    expect_v(16'h0060); read_io(v); check("pop_push_io", v);
    expect_v(16'h0816); cmd(4'h3, 4'h0); read_io(v); check("status_full", v);
    for (int i = 1; i < 8; i++) expect_v(32'h60 + 32'(i));
    expect_v(32'h70);
    for (int i = 0; i < 8; i++) begin
      cmd(4'h2, 4'h0); read_io(v); check("rx_drain", v);
    end

    // FLUSH wins over a same-cycle serial push
    sif.ser_rx_data = 16'h3300; sif.ser_rx_valid = 2'b10;
    tick();
    sif.ser_rx_data = 16'h4400;
    cmd(4'h4, 4'h1);
    sif.ser_rx_valid = 2'b00;
    expect_v(16'h000A); cmd(4'h3, 4'h1); read_io(v); check("flush_status", v);
    expect_v(0); check("flush_irq", irq);

    // Out-of-range channel, undefined opcode, load suppressed by command
    load(16'h1234);
    tb_bus = 16'h00F3; tb_drv = 1'b1; ctrl = 3'b101;
    tick();
    ctrl = 3'b000; tb_drv = 1'b0;
    expect_v(16'h1234); read_io(v); check("ch15_status", v);
    cmd(4'h1, 4'hF);
    expect_v(2'b00); check("ch15_push", sif.ser_tx_valid);
    cmd(4'h7, 4'h0);
    expect_v(16'h1234); read_io(v); check("bad_opcode", v);

    // Reset pulsed mid-burst
    load(16'h00AB);
    for (int i = 0; i < 3; i++) cmd(4'h1, 4'h0);
    sif.ser_rx_data = 16'h7700; sif.ser_rx_valid = 2'b10;
    tick();
    tick();
    sif.ser_rx_valid = 2'b00;
    expect_v(2'b01); check("pre_rst_tx", sif.ser_tx_valid);
    expect_v(1); check("pre_rst_irq", irq);
    #2;
    reset_n = 1'b0;
    #1;
    expect_v(2'b00); check("mid_rst_tx", sif.ser_tx_valid);
    expect_v(2'b11); check("mid_rst_rx_ready", sif.ser_rx_ready);
    expect_v(0); check("mid_rst_irq", irq);
    tick();
    reset_n = 1'b1;
    tick();
    expect_v(0); read_io(v); check("post_rst_io", v);
    expect_v(16'h000A); cmd(4'h3, 4'h0); read_io(v); check("post_rst_st0", v);
    expect_v(16'h000A); cmd(4'h3, 4'h1); read_io(v); check("post_rst_st1", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
